// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for one CLB. It hunts for a sync byte, shifts in a
// CFG_W-bit body MSB-first, then commits it to CFG only if even parity holds.
module clb_cfg_loader #(
  parameter int                 CFG_W   = 37,
  parameter logic [7:0]         SYNC    = 8'hA5,
  parameter logic [CFG_W-1:0]   CFG_RST = '0
) (
  input  logic             K,
  input  logic             RST,
  input  logic             DIN,
  input  logic             DVALID,
  input  logic             ABORT,
  output logic [CFG_W-1:0] CFG,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  typedef enum logic [1:0] {HUNT, LOAD, PAR} state_e;

  state_e             state_q, state_d;
  logic [7:0]         hunt_q, hunt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_comb begin
    state_d  = state_q;
    hunt_d   = hunt_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Abort wins over everything, including a parity bit arriving on the same cycle.
    if (ABORT) begin
      state_d = HUNT;
      hunt_d  = '0;
      cnt_d   = '0;
    end else if (DVALID) begin
      unique case (state_q)
        HUNT: begin
          hunt_d = {hunt_q[6:0], DIN};
          if ({hunt_q[6:0], DIN} == SYNC) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        LOAD: begin
          shadow_d = {shadow_q[CFG_W-2:0], DIN};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CFG_W - 1)) begin
            state_d = PAR;
          end
        end
        PAR: begin
          if (^{shadow_q, DIN} == 1'b0) begin
            cfg_d  = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          // Clearing hunt forces a fresh, non-overlapping sync for the next frame.
          state_d = HUNT;
          hunt_d  = '0;
          cnt_d   = '0;
        end
        default: begin
          state_d = HUNT;
          hunt_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state_q  <= HUNT;
      hunt_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= CFG_RST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hunt_q   <= hunt_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign CFG  = cfg_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule
